// File: rtl/i2c_pkg.sv
// Register map and status bit layout of the I2C slave register bank.
// Shared with the software header generator, so keep names stable.
package i2c_pkg;

  localparam logic [7:0] I2C_REG_CTRL   = 8'h40;
  localparam logic [7:0] I2C_REG_DIRTY  = 8'h44;
  localparam logic [7:0] I2C_REG_STATUS = 8'h48;
  localparam logic [7:0] I2C_REG_SADDR  = 8'h4C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STATUS_OOR     = 0;
  localparam int STATUS_COLL    = 1;
  localparam int STATUS_WR_SEEN = 2;

endpackage

// File: rtl/i2c_slave_regbank.sv
// Register bank shared between an upstream I2C slave and the core peripheral bus.
// I2C writes land one cycle after the valid rise; the I2C side wins every same-cycle conflict.
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter int         N_REGS         = 16,
  parameter logic [7:0] RST_SLAVE_ADDR = 8'hA0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        slv_enable_o,
  output logic [7:0]  slv_addr_o,
  input  logic [7:0]  slv_reg_addr_i,
  input  logic        slv_read_i,
  input  logic        slv_valid_i,
  input  logic [7:0]  slv_wdata_i,
  output logic [7:0]  slv_rdata_o
);

  localparam logic [5:0] W_CTRL   = I2C_REG_CTRL[7:2];
  localparam logic [5:0] W_DIRTY  = I2C_REG_DIRTY[7:2];
  localparam logic [5:0] W_STATUS = I2C_REG_STATUS[7:2];
  localparam logic [5:0] W_SADDR  = I2C_REG_SADDR[7:2];

  logic [7:0]        regs [N_REGS];
  logic [N_REGS-1:0] dirty;
  logic [N_REGS-1:0] dirty_set;
  logic [N_REGS-1:0] dirty_clr;
  logic [N_REGS-1:0] dirty_next;
  logic [N_REGS-1:0] core_reg_wr;
  logic [2:0]        status;
  logic [2:0]        status_set;
  logic [2:0]        status_clr;
  logic [2:0]        status_next;
  logic [1:0]        ctrl;
  logic [6:0]        saddr;

  logic              valid_q;
  logic              ev;
  logic              wr_p0;
  logic [7:0]        waddr_p0;
  logic [7:0]        wdata_p0;

  logic              core_wr;
  logic              core_rd;
  logic [5:0]        widx;
  logic              i2c_hit;
  logic [31:0]       rd_val;
  logic [7:0]        slv_rd_val;

  logic              rvalid;
  logic [31:0]       rdata;
  logic              irq;
  logic [7:0]        slv_rdata;

  logic              unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

  assign gnt_o        = req_i;
  assign rvalid_o     = rvalid;
  assign rdata_o      = rdata;
  assign irq_o        = irq;
  assign slv_enable_o = ctrl[CTRL_EN];
  assign slv_addr_o   = {saddr, 1'b0};
  assign slv_rdata_o  = slv_rdata;

  assign core_wr = req_i && we_i;
  assign core_rd = req_i && !we_i;
  assign widx    = addr_i[7:2];
  assign ev      = slv_valid_i && !valid_q;
  assign i2c_hit = wr_p0 && (int'(waddr_p0) < N_REGS);

  always_comb begin
    dirty_set   = '0;
    core_reg_wr = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (i2c_hit && (waddr_p0 == 8'(k))) dirty_set[k] = 1'b1;
      if (core_wr && (widx == 6'(k)))     core_reg_wr[k] = 1'b1;
    end
    dirty_clr  = (core_wr && (widx == W_DIRTY)) ? wdata_i[N_REGS-1:0] : '0;
    dirty_next = (dirty & ~dirty_clr) | dirty_set;

    status_set                 = '0;
    status_set[STATUS_OOR]     = wr_p0 && !i2c_hit;
    status_set[STATUS_COLL]    = |(dirty_set & core_reg_wr);
    status_set[STATUS_WR_SEEN] = wr_p0;
    status_clr  = (core_wr && (widx == W_STATUS)) ? wdata_i[2:0] : '0;
    status_next = (status & ~status_clr) | status_set;
  end

  always_comb begin
    rd_val     = '0;
    slv_rd_val = 8'hFF;
    for (int k = 0; k < N_REGS; k++) begin
      if (widx == 6'(k))              rd_val     = {24'd0, regs[k]};
      if (slv_reg_addr_i == 8'(k))    slv_rd_val = regs[k];
    end
    case (widx)
      W_CTRL:   rd_val = {30'd0, ctrl};
      W_DIRTY:  rd_val = 32'(dirty);
      W_STATUS: rd_val = {29'd0, status};
      W_SADDR:  rd_val = {24'd0, saddr, 1'b0};
      default:  ;
    endcase
  end

  // p0: capture the I2C write beat; the write lands in the following cycle
  always_ff @(posedge clk_i) begin
    if (ev) begin
      waddr_p0 <= slv_reg_addr_i;
      wdata_p0 <= slv_wdata_i;
    end
  end

  // valid_q resets high so a valid already asserted at reset release is not seen as a rise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b1;
      wr_p0     <= 1'b0;
      dirty     <= '0;
      status    <= '0;
      ctrl      <= '0;
      saddr     <= RST_SLAVE_ADDR[7:1];
      rvalid    <= 1'b0;
      rdata     <= '0;
      irq       <= 1'b0;
      slv_rdata <= 8'hFF;
      for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
    end else begin
      valid_q   <= slv_valid_i;
      wr_p0     <= ev && !slv_read_i;
      dirty     <= dirty_next;
      status    <= status_next;
      rvalid    <= req_i;
      rdata     <= core_rd ? rd_val : '0;
      irq       <= ctrl[CTRL_IRQ_EN] && (|dirty_next);
      slv_rdata <= slv_rd_val;
      for (int k = 0; k < N_REGS; k++) begin
        if (dirty_set[k])        regs[k] <= wdata_p0;
        else if (core_reg_wr[k]) regs[k] <= wdata_i[7:0];
      end
      if (core_wr && (widx == W_CTRL))  ctrl  <= wdata_i[1:0];
      if (core_wr && (widx == W_SADDR)) saddr <= wdata_i[7:1];
    end
  end

endmodule
